// File: rtl/j_stream_pkg.sv
// Shared types and helpers for the J-chunk streamer: FSM state encoding,
// default geometry and the chunk element layout function.
package j_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int unsigned J_DEF_MEM_BANDWIDTH   = 1024;
  localparam int unsigned J_DEF_VECTOR_SIZE     = 256;
  localparam int unsigned J_DEF_ELEMENT_WIDTH   = 4;
  localparam int unsigned J_DEF_COLS_PER_READ   =
    J_DEF_MEM_BANDWIDTH / (J_DEF_VECTOR_SIZE * J_DEF_ELEMENT_WIDTH);
  localparam int unsigned J_DEF_NUM_CHUNKS      = J_DEF_VECTOR_SIZE / J_DEF_COLS_PER_READ;

  // LSB position of element (row, lane) inside one memory word / chunk.
  function automatic int unsigned j_elem_lsb(input int unsigned row,
                                             input int unsigned lane,
                                             input int unsigned cols,
                                             input int unsigned elem_w);
    return (row * cols + lane) * elem_w;
  endfunction

endpackage

// File: rtl/j_chunk_streamer_fifo.sv
// Return buffer for the J-chunk streamer: first-word-fall-through FIFO with
// occupancy count and a synchronous flush that beats any same-cycle write.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             rd_do;

  assign empty   = (count == '0);
  assign rd_do   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_do) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_do);
    end
  end

endmodule

// File: rtl/j_chunk_streamer.sv
// Streams the J matrix chunk by chunk from fixed-latency memory over valid/ready.
// Define J_STREAM_PERF_EN to build the saturating consumer-stall counter.
module j_chunk_streamer
  import j_stream_pkg::*;
#(
  parameter int unsigned MEM_BANDWIDTH   = J_DEF_MEM_BANDWIDTH,
  parameter int unsigned VECTOR_SIZE     = J_DEF_VECTOR_SIZE,
  parameter int unsigned J_ELEMENT_WIDTH = J_DEF_ELEMENT_WIDTH,
  parameter int unsigned J_COLS_PER_READ = MEM_BANDWIDTH / (VECTOR_SIZE * J_ELEMENT_WIDTH),
  parameter int unsigned NUM_J_CHUNKS    = VECTOR_SIZE / J_COLS_PER_READ,
  parameter int unsigned MEM_LATENCY     = 2,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic                              abort,
  output logic                              busy,
  output logic                              done,
  output logic                              mem_req,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic [MEM_BANDWIDTH-1:0]          mem_rdata,
  output logic                              chunk_valid,
  input  logic                              chunk_ready,
  output logic [MEM_BANDWIDTH-1:0]          chunk_data,
  output logic [$clog2(NUM_J_CHUNKS)-1:0]   chunk_idx,
  output logic                              chunk_first,
  output logic                              chunk_last,
  output logic [31:0]                       stall_count
);

  localparam int unsigned IDX_W = $clog2(NUM_J_CHUNKS);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                   state;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic [IDX_W-1:0]         req_idx, out_idx;
  logic [MEM_LATENCY-1:0]   inflight_sr;
  logic [CNT_W-1:0]         in_flight, fifo_count;
  logic [MEM_BANDWIDTH-1:0] fifo_head;
  logic                     fifo_empty, fifo_wr, fifo_flush;
  logic                     start_acc, abort_acc, hs, last_req, last_hs;

  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < MEM_LATENCY; i++) in_flight += CNT_W'(inflight_sr[i]);
  end

  assign start_acc = start && !abort && (state == IDLE);
  assign abort_acc = abort && ((state == ISSUE) || (state == DRAIN));

  // Credit: a request is only issued if its return is guaranteed a FIFO slot.
  assign mem_req  = (state == ISSUE) &&
                    (({1'b0, in_flight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH));
  assign mem_addr = base_q + ADDR_WIDTH'(req_idx);
  assign last_req = mem_req && (req_idx == IDX_W'(NUM_J_CHUNKS - 1));

  assign chunk_valid = !fifo_empty;
  assign hs          = chunk_valid && chunk_ready;
  assign last_hs     = hs && (out_idx == IDX_W'(NUM_J_CHUNKS - 1));
  assign chunk_data  = chunk_valid ? fifo_head : '0;
  assign chunk_idx   = out_idx;
  assign chunk_first = chunk_valid && (out_idx == '0);
  assign chunk_last  = chunk_valid && (out_idx == IDX_W'(NUM_J_CHUNKS - 1));
  assign busy        = (state != IDLE);

  assign fifo_flush = abort_acc || (state == FLUSH);
  assign fifo_wr    = inflight_sr[MEM_LATENCY-1] && !fifo_flush;

  sync_fifo #(
    .WIDTH (MEM_BANDWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (fifo_flush),
    .wr_en   (fifo_wr),
    .wr_data (mem_rdata),
    .rd_en   (hs),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // DRAIN lingers for the done cycle so busy stays high while done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      base_q      <= '0;
      req_idx     <= '0;
      out_idx     <= '0;
      inflight_sr <= '0;
      done        <= 1'b0;
    end else begin
      inflight_sr <= (inflight_sr << 1) | MEM_LATENCY'(mem_req);
      done        <= 1'b0;
      if (mem_req) req_idx <= req_idx + 1'b1;
      if (hs)      out_idx <= out_idx + 1'b1;
      case (state)
        IDLE: begin
          if (start_acc) begin
            base_q  <= base_addr;
            req_idx <= '0;
            out_idx <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (abort)         state <= FLUSH;
          else if (last_req) state <= DRAIN;
        end
        DRAIN: begin
          if (abort)        state <= FLUSH;
          else if (done)    state <= IDLE;
          else if (last_hs) done  <= 1'b1;
        end
        FLUSH: begin
          if (in_flight == '0) state <= IDLE;
        end
      endcase
    end
  end

`ifdef J_STREAM_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                    stall_q <= '0;
    else if (start_acc)                                         stall_q <= '0;
    else if (chunk_valid && !chunk_ready && (stall_q != '1))    stall_q <= stall_q + 1'b1;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_j_chunk_streamer.sv
// Directed self-checking bench for j_chunk_streamer (64-bit words, 2 lanes, 4 chunks).
module tb_j_chunk_streamer;

  localparam int NCYC = 40;
`ifdef J_STREAM_PERF_EN
  localparam logic [31:0] TOG_STALL  = 32'd3;
  localparam logic [31:0] HOLD_STALL = 32'd6;
`else
  localparam logic [31:0] TOG_STALL  = 32'd0;
  localparam logic [31:0] HOLD_STALL = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort, chunk_ready;
  logic [15:0] base_addr;
  logic        busy, done, mem_req, chunk_valid, chunk_first, chunk_last;
  logic [15:0] mem_addr;
  logic [63:0] mem_rdata, chunk_data;
  logic [1:0]  chunk_idx;
  logic [31:0] stall_count;

  int   errors = 0;
  int   checks = 0;
  logic ovf    = 1'b0;

  logic        r_req   [NCYC];
  logic [15:0] r_addr  [NCYC];
  logic        r_valid [NCYC];
  logic [1:0]  r_idx   [NCYC];
  logic [63:0] r_data  [NCYC];
  logic        r_first [NCYC];
  logic        r_last  [NCYC];
  logic        r_done  [NCYC];
  logic        r_busy  [NCYC];
  logic        r_ready [NCYC];
  logic [31:0] r_stall [NCYC];

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input logic [15:0] a);
    logic [3:0] nib;
    nib = a[3:0];
    return {16{nib}};
  endfunction

  // Memory model: two-cycle read pipeline.
  logic [15:0] pipe0 = '0, pipe1 = '0;
  always @(posedge clk) begin
    pipe0 <= mem_addr;
    pipe1 <= pipe0;
  end
  assign mem_rdata = word(pipe1);

  always @(negedge clk) if (dut.fifo_count > 3'd4) ovf = 1'b1;

  j_chunk_streamer #(
    .MEM_BANDWIDTH   (64),
    .VECTOR_SIZE     (8),
    .J_ELEMENT_WIDTH (4),
    .J_COLS_PER_READ (2),
    .NUM_J_CHUNKS    (4),
    .MEM_LATENCY     (2),
    .FIFO_DEPTH      (4),
    .ADDR_WIDTH      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .chunk_data  (chunk_data),
    .chunk_idx   (chunk_idx),
    .chunk_first (chunk_first),
    .chunk_last  (chunk_last),
    .stall_count (stall_count)
  );

  // Cycle 0 carries the start pulse; mode 0: ready=1, 1: ready on even cycles, 2: ready from cycle 10.
  task automatic run(input logic [15:0] base, input int mode, input int abort_c,
                     input int rst_c, input int n);
    for (int c = 0; c < n; c++) begin
      start     = (c == 0);
      base_addr = base;
      abort     = (c == abort_c);
      rst       = (c == rst_c);
      case (mode)
        0:       chunk_ready = 1'b1;
        1:       chunk_ready = (c % 2 == 0);
        default: chunk_ready = (c >= 10);
      endcase
      @(negedge clk);
      r_req[c] = mem_req;   r_addr[c] = mem_addr;  r_valid[c] = chunk_valid;
      r_idx[c] = chunk_idx; r_data[c] = chunk_data; r_first[c] = chunk_first;
      r_last[c] = chunk_last; r_done[c] = done; r_busy[c] = busy;
      r_ready[c] = chunk_ready; r_stall[c] = stall_count;
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0; chunk_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, mem_req, chunk_valid, chunk_first, chunk_last} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
                         {busy, done, mem_req, chunk_valid, chunk_first, chunk_last});
    end
    checks++;
    if (mem_addr !== 16'h0 || chunk_idx !== 2'd0 || chunk_data !== 64'h0 || stall_count !== 32'h0) begin
      errors++; $display("FAIL reset_values: addr=%0h idx=%0d data=%0h stall=%0d want all 0",
                         mem_addr, chunk_idx, chunk_data, stall_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] a;
    run(16'h0010, 0, -1, -1, 12);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (r_req[c] !== (c >= 1 && c <= 4)) begin
        errors++; $display("FAIL basic_req c%0d: got %b want %b", c, r_req[c], (c >= 1 && c <= 4));
      end
      if (c >= 1 && c <= 4) begin
        a = 16'(16'h0010 + c - 1);
        checks++;
        if (r_addr[c] !== a) begin
          errors++; $display("FAIL basic_addr c%0d: got %0h want %0h", c, r_addr[c], a);
        end
      end
      checks++;
      if (r_valid[c] !== (c >= 4 && c <= 7)) begin
        errors++; $display("FAIL basic_valid c%0d: got %b want %b", c, r_valid[c], (c >= 4 && c <= 7));
      end
      if (c >= 4 && c <= 7) begin
        a = 16'(16'h0010 + c - 4);
        checks++;
        if (r_idx[c] !== 2'(c - 4) || r_data[c] !== word(a) ||
            r_first[c] !== (c == 4) || r_last[c] !== (c == 7)) begin
          errors++; $display("FAIL basic_chunk c%0d: idx=%0d data=%0h first=%b last=%b want idx=%0d data=%0h first=%b last=%b",
                             c, r_idx[c], r_data[c], r_first[c], r_last[c], c - 4, word(a), (c == 4), (c == 7));
        end
      end
      checks++;
      if (r_done[c] !== (c == 8)) begin
        errors++; $display("FAIL basic_done c%0d: got %b want %b", c, r_done[c], (c == 8));
      end
      checks++;
      if (r_busy[c] !== (c >= 1 && c <= 8)) begin
        errors++; $display("FAIL basic_busy c%0d: got %b want %b", c, r_busy[c], (c >= 1 && c <= 8));
      end
    end
  endtask

  task automatic test_toggle_ready();
    int n = 0;
    int dones = 0;
    run(16'h0030, 1, -1, -1, 16);
    for (int c = 0; c < 16; c++) begin
      if (c > 0 && r_valid[c-1] && !r_ready[c-1]) begin
        checks++;
        if (r_valid[c] !== 1'b1 || r_idx[c] !== r_idx[c-1] || r_data[c] !== r_data[c-1]) begin
          errors++; $display("FAIL toggle_stable c%0d: valid=%b idx=%0d data=%0h want 1 %0d %0h",
                             c, r_valid[c], r_idx[c], r_data[c], r_idx[c-1], r_data[c-1]);
        end
      end
      if (r_valid[c] && r_ready[c]) begin
        checks++;
        if (r_idx[c] !== 2'(n) || r_data[c] !== word(16'(16'h0030 + n))) begin
          errors++; $display("FAIL toggle_order c%0d: idx=%0d data=%0h want %0d %0h",
                             c, r_idx[c], r_data[c], n, word(16'(16'h0030 + n)));
        end
        n++;
      end
      if (r_done[c]) dones++;
    end
    checks++;
    if (n != 4 || dones != 1) begin
      errors++; $display("FAIL toggle_count: chunks=%0d dones=%0d want 4 1", n, dones);
    end
    checks++;
    if (r_stall[15] !== TOG_STALL) begin
      errors++; $display("FAIL toggle_stall: got %0d want %0d", r_stall[15], TOG_STALL);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL toggle_overflow: got %b want 0", ovf);
    end
  endtask

  task automatic test_hold_ready();
    int reqs = 0;
    int n = 0;
    int first_hs = -1;
    run(16'h0050, 2, -1, -1, 22);
    for (int c = 0; c < 10; c++) if (r_req[c]) reqs++;
    checks++;
    if (reqs != 4) begin
      errors++; $display("FAIL hold_reqs: got %0d want 4", reqs);
    end
    for (int c = 0; c < 22; c++) begin
      if (r_valid[c] && r_ready[c]) begin
        if (first_hs < 0) first_hs = c;
        checks++;
        if (r_idx[c] !== 2'(n) || r_data[c] !== word(16'(16'h0050 + n))) begin
          errors++; $display("FAIL hold_order c%0d: idx=%0d data=%0h want %0d %0h",
                             c, r_idx[c], r_data[c], n, word(16'(16'h0050 + n)));
        end
        n++;
      end
    end
    checks++;
    if (n != 4 || first_hs != 10 || r_done[14] !== 1'b1) begin
      errors++; $display("FAIL hold_resume: chunks=%0d first_hs=%0d done14=%b want 4 10 1",
                         n, first_hs, r_done[14]);
    end
    checks++;
    if (r_stall[21] !== HOLD_STALL) begin
      errors++; $display("FAIL hold_stall: got %0d want %0d", r_stall[21], HOLD_STALL);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL hold_overflow: got %b want 0", ovf);
    end
  endtask

  task automatic test_addr_wrap();
    logic [15:0] exp_a [4];
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    run(16'hFFFE, 0, -1, -1, 12);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (r_req[k+1] !== 1'b1 || r_addr[k+1] !== exp_a[k]) begin
        errors++; $display("FAIL wrap_addr k%0d: req=%b addr=%0h want 1 %0h", k, r_req[k+1], r_addr[k+1], exp_a[k]);
      end
      checks++;
      if (r_data[k+4] !== word(exp_a[k])) begin
        errors++; $display("FAIL wrap_data k%0d: got %0h want %0h", k, r_data[k+4], word(exp_a[k]));
      end
    end
  endtask

  task automatic test_abort();
    int vcnt = 0;
    int dones = 0;
    int n = 0;
    run(16'h0070, 0, 3, -1, 12);
    for (int c = 4; c < 12; c++) if (r_valid[c]) vcnt++;
    for (int c = 0; c < 12; c++) if (r_done[c]) dones++;
    checks++;
    if (r_valid[4] !== 1'b0 || vcnt != 0) begin
      errors++; $display("FAIL abort_valid: valid4=%b valid_cycles=%0d want 0 0", r_valid[4], vcnt);
    end
    checks++;
    if (r_busy[6] !== 1'b1 || r_busy[7] !== 1'b0) begin
      errors++; $display("FAIL abort_busy: busy6=%b busy7=%b want 1 0", r_busy[6], r_busy[7]);
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL abort_done: got %0d pulses want 0", dones);
    end
    run(16'h0020, 0, -1, -1, 12);
    for (int c = 0; c < 12; c++) begin
      if (r_valid[c] && r_ready[c]) begin
        checks++;
        if (c != n + 4 || r_idx[c] !== 2'(n) || r_data[c] !== word(16'(16'h0020 + n))) begin
          errors++; $display("FAIL abort_restart c%0d: idx=%0d data=%0h want c%0d %0d %0h",
                             c, r_idx[c], r_data[c], n + 4, n, word(16'(16'h0020 + n)));
        end
        n++;
      end
    end
    checks++;
    if (n != 4 || r_done[8] !== 1'b1) begin
      errors++; $display("FAIL abort_restart_done: chunks=%0d done8=%b want 4 1", n, r_done[8]);
    end
  endtask

  task automatic test_reset_mid();
    int late = 0;
    run(16'h0090, 0, -1, 5, 12);
    checks++;
    if ({r_busy[5], r_req[5], r_valid[5], r_done[5], r_first[5], r_last[5]} !== 6'b0 ||
        r_idx[5] !== 2'd0 || r_data[5] !== 64'h0 || r_addr[5] !== 16'h0 || r_stall[5] !== 32'h0) begin
      errors++; $display("FAIL midreset_outputs: busy=%b req=%b valid=%b idx=%0d data=%0h addr=%0h stall=%0d want all 0",
                         r_busy[5], r_req[5], r_valid[5], r_idx[5], r_data[5], r_addr[5], r_stall[5]);
    end
    for (int c = 6; c < 12; c++) if (r_valid[c] || r_busy[c]) late++;
    checks++;
    if (late != 0) begin
      errors++; $display("FAIL midreset_late_return: got %0d active cycles want 0", late);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; chunk_ready = 1'b0; base_addr = '0;
    test_reset();
    test_basic();
    test_toggle_ready();
    test_hold_ready();
    test_addr_wrap();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
